// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg : shared constants and types for the seven-segment scan driver
// Revision: 1.0
// ============================================================================
package seg_pkg;

  localparam int unsigned DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [$clog2(DIGITS)-1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [DIGITS-1:0] anode_for(input digit_idx_t idx);
    logic [DIGITS-1:0] an;
    an      = AN_OFF;
    an[idx] = 1'b0;
    return an;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_hex_to_seg.sv
`default_nettype none
// ============================================================================
// hex_to_seg : combinational nibble to active-low seven-segment glyph
// Revision: 1.0
// ============================================================================
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_FONT[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver : 4-digit common-anode display scanner with per-frame
//                   word capture, leading-zero blanking and decimal points
// Revision: 1.0
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  input  logic        Enable,
  input  logic        LzBlank,
  input  logic [3:0]  DpMask,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        FrameStart
);

  localparam int unsigned    PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PCNT_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          fs_q;

  logic        frame_start;
  logic [15:0] src;
  logic [3:0]  nibble;
  logic [3:0]  shamt;
  logic        blank;
  logic [6:0]  glyph;

  assign frame_start = (pcnt_q == '0) && (idx_q == '0);
  // The capture cycle decodes the incoming word directly so digit 0 is
  // never one frame stale relative to the rest of the frame.
  assign src    = frame_start ? DataIn : shadow_q;
  assign shamt  = {idx_q, 2'b00};
  assign nibble = src[shamt +: 4];
  assign blank  = (idx_q != '0) && LzBlank && ((src >> shamt) == 16'h0000);

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    pcnt_d   = pcnt_q + 1'b1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;

    if (pcnt_q == PCNT_MAX) begin
      pcnt_d = '0;
      idx_d  = idx_q + 1'b1;
    end

    if (frame_start) begin
      shadow_d = DataIn;
    end

    if (Enable && !blank) begin
      an_d  = anode_for(idx_q);
      seg_d = {~DpMask[idx_q], glyph};
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      shadow_q <= 16'h0000;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      fs_q     <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fs_q     <= frame_start;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign FrameStart = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_driver : bench for seg_scan_driver with REFRESH_DIV = 4
// Revision: 1.0
// ============================================================================
module tb_seg_scan_driver;

  localparam int DIV = 4;

  logic        CLK;
  logic        Reset;
  logic [15:0] DataIn;
  logic        Enable;
  logic        LzBlank;
  logic [3:0]  DpMask;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        FrameStart;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .DataIn     (DataIn),
    .Enable     (Enable),
    .LzBlank    (LzBlank),
    .DpMask     (DpMask),
    .AN         (AN),
    .SEG        (SEG),
    .FrameStart (FrameStart)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        en;
    logic        lz;
    logic [3:0]  dp;
    logic [3:0]  an  [4];
    logic [7:0]  seg [4];
  } vec_t;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t        sb [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          m_pcnt   = 0;
  int          m_idx    = 0;
  logic [15:0] m_shadow = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pcnt   = 0;
    m_idx    = 0;
    m_shadow = 16'h0000;
    sb.delete();
  endtask

  // Predict the registered outputs of the coming edge, advance the model,
  // clock the DUT, then pop and compare.
  task automatic cycle();
    exp_t        e;
    logic        fs;
    logic [15:0] src;
    logic [3:0]  nib;
    logic        blank;
    fs    = (m_pcnt == 0) && (m_idx == 0);
    src   = fs ? DataIn : m_shadow;
    nib   = src[m_idx*4 +: 4];
    blank = (m_idx != 0) && LzBlank && ((src >> (m_idx*4)) == 16'h0000);
    e.an  = 4'hF;
    e.seg = 8'hFF;
    if (Enable && !blank) begin
      e.an[m_idx] = 1'b0;
      e.seg       = {~DpMask[m_idx], font[nib]};
    end
    e.fs = fs;
    sb.push_back(e);
    if (fs) m_shadow = DataIn;
    if (m_pcnt == DIV - 1) begin
      m_pcnt = 0;
      m_idx  = (m_idx + 1) % 4;
    end else begin
      m_pcnt++;
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      check("scoreboard", {19'h0, AN, SEG, FrameStart}, {19'h0, e.an, e.seg, e.fs});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (FrameStart !== 1'b1 && k < 40);
    if (FrameStart !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL framestart_timeout actual=%0d required=<40 cycles", k);
    end
  endtask

  vec_t vecs [8];
  int   t0;

  initial begin
    vecs[0] = '{16'h1234, 1, 0, 4'h0, '{4'hE,4'hD,4'hB,4'h7}, '{8'h99,8'hB0,8'hA4,8'hF9}};
    vecs[1] = '{16'hABCD, 1, 0, 4'h0, '{4'hE,4'hD,4'hB,4'h7}, '{8'hA1,8'hC6,8'h83,8'h88}};
    vecs[2] = '{16'h0005, 1, 1, 4'h0, '{4'hE,4'hF,4'hF,4'hF}, '{8'h92,8'hFF,8'hFF,8'hFF}};
    vecs[3] = '{16'h0000, 1, 1, 4'h0, '{4'hE,4'hF,4'hF,4'hF}, '{8'hC0,8'hFF,8'hFF,8'hFF}};
    vecs[4] = '{16'hFFFF, 1, 0, 4'h4, '{4'hE,4'hD,4'hB,4'h7}, '{8'h8E,8'h8E,8'h0E,8'h8E}};
    vecs[5] = '{16'h1234, 0, 0, 4'h0, '{4'hF,4'hF,4'hF,4'hF}, '{8'hFF,8'hFF,8'hFF,8'hFF}};
    vecs[6] = '{16'h0100, 1, 1, 4'h0, '{4'hE,4'hD,4'hB,4'hF}, '{8'hC0,8'hC0,8'hF9,8'hFF}};
    vecs[7] = '{16'h89EF, 1, 0, 4'h9, '{4'hE,4'hD,4'hB,4'h7}, '{8'h0E,8'h86,8'h90,8'h00}};

    Reset   = 1'b1;
    DataIn  = 16'h0000;
    Enable  = 1'b1;
    LzBlank = 1'b0;
    DpMask  = 4'h0;
    #1;
    check("reset_an",  {28'h0, AN},  {28'h0, 4'hF});
    check("reset_seg", {24'h0, SEG}, {24'h0, 8'hFF});
    check("reset_fs",  {31'h0, FrameStart}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();

    for (int v = 0; v < 8; v++) begin
      DataIn  = vecs[v].data;
      Enable  = vecs[v].en;
      LzBlank = vecs[v].lz;
      DpMask  = vecs[v].dp;
      wait_fs();
      for (int d = 0; d < 4; d++) begin
        check($sformatf("vec%0d_an%0d", v, d),  {28'h0, AN},  {28'h0, vecs[v].an[d]});
        check($sformatf("vec%0d_seg%0d", v, d), {24'h0, SEG}, {24'h0, vecs[v].seg[d]});
        run(DIV);
      end
    end

    // Mid-frame DataIn change is held off by the shadow register
    DataIn = 16'h1234; Enable = 1'b1; LzBlank = 1'b0; DpMask = 4'h0;
    wait_fs();
    wait_fs();
    run(5);
    DataIn = 16'hABCD;
    run(3);
    check("midframe_d2", {20'h0, AN, SEG}, {20'h0, 4'hB, 8'hA4});
    run(4);
    check("midframe_d3", {20'h0, AN, SEG}, {20'h0, 4'h7, 8'hF9});
    run(4);
    check("newframe_d0", {19'h0, AN, SEG, FrameStart}, {19'h0, 4'hE, 8'hA1, 1'b1});

    // Enable off for a frame: dark, but frame period unchanged
    t0 = cyc;
    run(3);
    Enable = 1'b0;
    wait_fs();
    check("dark_period", cyc - t0, 16);
    check("dark_out", {20'h0, AN, SEG}, {20'h0, 4'hF, 8'hFF});
    t0 = cyc;
    run(6);
    Enable = 1'b1;
    wait_fs();
    check("reenable_period", cyc - t0, 16);
    check("reenable_d0", {20'h0, AN, SEG}, {20'h0, 4'hE, 8'hA1});

    // Asynchronous reset during digit 2
    run(9);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_out", {19'h0, AN, SEG, FrameStart}, {19'h0, 4'hF, 8'hFF, 1'b0});
    model_reset();
    @(posedge CLK);
    #1;
    check("reset_hold_out", {20'h0, AN, SEG}, {20'h0, 4'hF, 8'hFF});
    Reset = 1'b0;
    cycle();
    check("post_reset_d0", {19'h0, AN, SEG, FrameStart}, {19'h0, 4'hE, 8'hA1, 1'b1});
    t0 = cyc;
    wait_fs();
    check("post_reset_period", cyc - t0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It consumes the 16-bit word chosen by the upstream 4:1 display selector and shows it as four hex digits. It scans one digit at a time and latches the word once per frame so no digit tears. It is the output end of the multi-cycle CPU's debug-display path.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is lit (1 ms at 100 MHz); legal range 2..2^20.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- DataIn  input  16  word to display; nibble [3:0] is the rightmost digit.
- Enable  input  1  1 = display on, 0 = all digits dark. Scanning continues while low.
- LzBlank  input  1  1 = blank leading zero digits.
- DpMask  input  4  bit i lights the decimal point of digit i.
- AN  output  4  digit anodes, active-low; AN[0] is the rightmost digit.
- SEG  output  8  cathodes, active-low; [6:0] = g..a, [7] = dp.
- FrameStart  output  1  one-cycle pulse when digit 0 of a new frame first appears.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and then wraps to 0.
- Digit index `idx` (2 bits) advances 0→1→2→3→0 on the cycle `pcnt` wraps.
- Frame-start cycle: `pcnt`==0 and `idx`==0. On this cycle `shadow` <= DataIn.
- Decode source `src` is DataIn on the frame-start cycle, otherwise `shadow`.
- Selected nibble = src[4*idx+3 : 4*idx].
- Hex font, active-low {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- SEG[7] = ~DpMask[idx].
- Leading-zero blanking: digit idx (idx≠0) is blanked when LzBlank=1 and src nibbles idx..3 are all zero. A blanked digit drives SEG=FF and AN all 1. Digit 0 is never blanked.
- Enable=0: AN=1111 and SEG=FF. `pcnt`, `idx` and `shadow` keep running.
- AN for a lit digit has bit idx low and all other bits high. At most one bit is ever low.

## Timing
- AN, SEG and FrameStart are registered. They reflect the `idx`/`src` of the previous cycle (1-cycle latency).
- A DataIn change becomes visible only at the next frame-start capture. It appears on AN/SEG one cycle after that capture. Worst case is 4·REFRESH_DIV+1 cycles.
- Frame period is exactly 4·REFRESH_DIV cycles. Each digit is driven for exactly REFRESH_DIV consecutive cycles.
- FrameStart is high on the cycle after each frame-start cycle, once per frame, regardless of Enable.
- Reset, asynchronous and effective immediately:
  - pcnt=0, idx=0, shadow=0000
  - AN=1111, SEG=FF, FrameStart=0
  - The first cycle after release is a frame-start cycle.
- Reset mid-frame abandons the frame. No partial digit time carries over.
- Enable or LzBlank toggling mid-frame takes effect on the next cycle's registered output. The scan phase is unaffected.
- REFRESH_DIV=2 is the minimum. Each digit then lasts 2 cycles with no gaps.

## Structure
- Package `seg_pkg`:
  - the 16-entry hex font constant
  - SEG_OFF=8'hFF and AN_OFF=4'hF
  - digit-count constant 4
- Sub-module `hex_to_seg`: combinational nibble → 7-bit active-low font. Instantiated once, fed by the selected nibble.
- Top level holds the prescaler, index, shadow register, blanking logic and output registers.

## Test plan
Run all scenarios with REFRESH_DIV=4.
- Reset, then DataIn=1234, Enable=1, LzBlank=0, DpMask=0:
  - (AN,SEG) sequence (E,99) (D,B0) (B,A4) (7,F9) repeats
  - each pair lasts 4 cycles
  - FrameStart pulses every 16 cycles
- DataIn changes from 1234 to ABCD at cycle 6 of a frame:
  - the rest of the frame still shows 1,2,3 (held in shadow)
  - the next frame shows (E,A1) (D,C6) (B,83) (7,88)
- DataIn=0005, LzBlank=1: digit 0 shows SEG=92; digits 1–3 show AN=F, SEG=FF. DataIn=0000 gives digit 0 SEG=C0.
- DpMask=0100, DataIn=FFFF: digit 2 SEG=0E; the other digits SEG=8E.
- Enable=0 for one frame: AN=F, SEG=FF throughout, but FrameStart still pulses every 16 cycles. On re-enable the scan phase is unchanged.
- Assert Reset during digit 2:
  - AN=F, SEG=FF immediately, with no clock edge needed
  - after release, digit 0 appears on the second cycle and FrameStart pulses on that same cycle
